// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester resource arbiter.
//   N_REQ  : number of requesters
//   ID_W   : width of a requester index
//   state_t: arbiter FSM states
//   rotate : reorders a request vector for round-robin arbitration
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Position j of the result holds request (last + j) mod N_REQ, so request
    // (last - 1) mod N_REQ lands at the top position and the last owner at
    // the bottom. A highest-bit-wins picker on this vector then searches
    // downward from (last - 1) and reaches the last owner only at the end.
    function automatic logic [N_REQ-1:0] rotate(input logic [N_REQ-1:0] vec,
                                                input logic [ID_W-1:0]  last);
        logic [N_REQ-1:0] rot;
        logic [ID_W-1:0]  src;
        rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            src    = ID_W'(j) + last;
            rot[j] = vec[src];
        end
        return rot;
    endfunction

endpackage

// File: rtl/arb_pick_4.sv
// ---------------------------------------------------------------------------
// arb_pick_4
// Combinational four-input priority picker; the highest set bit wins.
//   vec : candidate request vector
//   idx : index of the winning bit (0 when nothing is set)
//   hit : at least one bit of vec is set
// ---------------------------------------------------------------------------
module arb_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             hit
);

    always_comb begin
        idx = '0;
        hit = |vec;
        if (vec[3]) begin
            idx = 2'd3;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[1]) begin
            idx = 2'd1;
        end
    end

endmodule

// File: rtl/resource_arbiter.sv
// ---------------------------------------------------------------------------
// resource_arbiter
// Shares one downstream resource among four requesters with a grant/release
// handshake. Fixed-priority or round-robin selection, grant held until the
// owner releases or withdraws, with an optional maximum hold time.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   rr_en     : 0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   req       : request vector, bit i is requester i
//   rel       : current owner has finished ("release" is a reserved word)
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : index of current owner, meaningful while gnt_valid is high
//   gnt_valid : any grant asserted
//   timeout   : one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module resource_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rr_en,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam bit               HOLD_ON  = (HOLD_MAX != 0);

    state_t           state, state_n;
    logic [ID_W-1:0]  last_id, last_id_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic [N_REQ-1:0] gnt_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_n;

    logic [N_REQ-1:0] pick_vec;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_hit;
    logic [ID_W-1:0]  winner;
    logic             end_grant;
    logic             hold_expired;

    // In round-robin mode the picker sees the rotated vector; adding last_id
    // back maps the rotated position to the real requester index.
    assign pick_vec = rr_en ? rotate(req, last_id) : req;
    assign winner   = rr_en ? pick_idx + last_id : pick_idx;

    arb_pick_4 u_pick (
        .vec (pick_vec),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    // A normal end of grant always wins over the hold limit, so a release in
    // the final allowed cycle never raises timeout.
    assign end_grant    = rel | ~req[gnt_id];
    assign hold_expired = HOLD_ON && (cnt == HOLD_LIM) && !end_grant;

    // State and all outputs are registered so nothing passes combinationally
    // from inputs to outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            last_id <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            last_id <= last_id_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

    // Next-state: any request starts a grant; a grant ends on release,
    // withdrawal or an expired hold, always passing through IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_hit) state_n = BUSY;
            BUSY:    if (end_grant || hold_expired) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs. Non-owner requests are not
    // looked at during BUSY, so there is no preemption.
    always_comb begin
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        last_id_n = last_id;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (pick_hit) begin
                    gnt_n     = N_REQ'(1) << winner;
                    gnt_id_n  = winner;
                    last_id_n = winner;
                    cnt_n     = CNT_W'(1);
                end
            end
            BUSY: begin
                if (end_grant || hold_expired) begin
                    gnt_n     = '0;
                    cnt_n     = '0;
                    timeout_n = hold_expired;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                gnt_n = '0;
            end
        endcase
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_resource_arbiter.sv
// ---------------------------------------------------------------------------
// tb_resource_arbiter
// Directed self-checking bench for resource_arbiter with a hold limit of 4.
// Each observation packs {gnt, gnt_id, gnt_valid, timeout} into one byte and
// compares it against a hand-computed expectation.
// ---------------------------------------------------------------------------
module tb_resource_arbiter;

    logic       clk;
    logic       rst;
    logic       rr_en;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks;
    int errors;

    resource_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rr_en     (rr_en),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] obs_now();
        return {gnt, gnt_id, gnt_valid, timeout};
    endfunction

    // Drives inputs for one clock edge and returns 1 ns after that edge so the
    // registered outputs reflect the edge that just sampled these inputs.
    task automatic applyStimulus(input logic m, input logic [3:0] r, input logic rl);
        rr_en = m;
        req   = r;
        rel   = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        rst = 1'b1;
        applyStimulus(1'b0, 4'b1111, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        rst = 1'b0;
        o = obs_now();
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected %b", o, 8'h00);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        o = obs_now();
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL idle_no_req: got %b expected %b", o, 8'h00);
        end
    endtask

    task automatic test_fixed_priority();
        logic [7:0] o;
        logic [7:0] exp_o;
        applyStimulus(1'b0, 4'b0101, 1'b0);
        o = obs_now(); exp_o = {4'b0100, 2'd2, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL fixed_grant: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0101, 1'b1);
        o = obs_now(); exp_o = {4'b0000, 2'd2, 1'b0, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL fixed_bubble: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0101, 1'b0);
        o = obs_now(); exp_o = {4'b0100, 2'd2, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL fixed_regrant: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        o = obs_now(); exp_o = {4'b0010, 2'd1, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL fixed_high_index: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic test_round_robin();
        logic [7:0] o;
        logic [7:0] exp_o;
        int         ids [5] = '{3, 2, 1, 0, 3};
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'b1111, 1'b0);
            o = obs_now();
            exp_o = {4'b0001 << ids[i], 2'(ids[i]), 1'b1, 1'b0};
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", i, o, exp_o);
            end
            applyStimulus(1'b1, 4'b1111, 1'b1);
            o = obs_now();
            exp_o = {4'b0000, 2'(ids[i]), 1'b0, 1'b0};
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("[TB] FAIL rr_bubble_%0d: got %b expected %b", i, o, exp_o);
            end
        end
    endtask

    // Grant to owner `id` is expected to persist for 4 cycles, then drop with
    // a single timeout pulse.
    task automatic run_timeout(input logic m, input logic [3:0] r, input int id, input string tag);
        logic [7:0] o;
        logic [7:0] exp_o;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(m, r, 1'b0);
            o = obs_now();
            exp_o = {4'b0001 << id, 2'(id), 1'b1, 1'b0};
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("[TB] FAIL %s_hold_%0d: got %b expected %b", tag, c, o, exp_o);
            end
        end
        applyStimulus(m, r, 1'b0);
        o = obs_now();
        exp_o = {4'b0000, 2'(id), 1'b0, 1'b1};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL %s_expire: got %b expected %b", tag, o, exp_o);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] o;
        logic [7:0] exp_o;
        run_timeout(1'b0, 4'b0010, 1, "to_fixed");
        applyStimulus(1'b0, 4'b0010, 1'b0);
        o = obs_now(); exp_o = {4'b0010, 2'd1, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL to_fixed_regrant: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        // last_id is 1: round-robin order 0,3,2,1 picks 2 first, then 1.
        run_timeout(1'b1, 4'b0110, 2, "to_rr");
        applyStimulus(1'b1, 4'b0110, 1'b0);
        o = obs_now(); exp_o = {4'b0010, 2'd1, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL to_rr_other_wins: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
    endtask

    task automatic test_withdraw_collision();
        logic [7:0] o;
        logic [7:0] exp_o;
        applyStimulus(1'b0, 4'b0100, 1'b0);
        o = obs_now(); exp_o = {4'b0100, 2'd2, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL wd_grant: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        o = obs_now(); exp_o = {4'b0000, 2'd2, 1'b0, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL wd_drop: got %b expected %b", o, exp_o);
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'b1000, 1'b0);
            o = obs_now(); exp_o = {4'b1000, 2'd3, 1'b1, 1'b0};
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("[TB] FAIL col_hold_%0d: got %b expected %b", c, o, exp_o);
            end
        end
        applyStimulus(1'b0, 4'b1000, 1'b1);
        o = obs_now(); exp_o = {4'b0000, 2'd3, 1'b0, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL col_release_wins: got %b expected %b", o, exp_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] o;
        logic [7:0] exp_o;
        applyStimulus(1'b1, 4'b1000, 1'b0);
        o = obs_now(); exp_o = {4'b1000, 2'd3, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL rst_mid_grant: got %b expected %b", o, exp_o);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 4'b1000, 1'b0);
        rst = 1'b0;
        o = obs_now();
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_clears: got %b expected %b", o, 8'h00);
        end
        applyStimulus(1'b1, 4'b1001, 1'b0);
        o = obs_now(); exp_o = {4'b1000, 2'd3, 1'b1, 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("[TB] FAIL rst_last_id: got %b expected %b", o, exp_o);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rr_en  = 1'b0;
        req    = 4'b0000;
        rel    = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_withdraw_collision();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

Four-requester arbiter that shares one downstream resource using a grant/release handshake. It selects among requesters in either fixed priority or round-robin order, holds the grant until the owner finishes, and enforces a maximum hold time. It sits between the requesting agents and the shared datapath and drives that datapath's select lines from the registered one-hot grant.

## Interface
- HOLD_MAX, 15, maximum number of consecutive cycles one owner may hold the grant; 0 disables the timeout.
- CNT_W, 4, width of the hold counter; must satisfy HOLD_MAX < 2**CNT_W.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rr_en  in  1  arbitration mode: 0 = fixed priority, 1 = round-robin; sampled only on arbitration cycles.
- req  in  4  request vector; bit i is requester i.
- release  in  1  current owner has finished; ignored in IDLE.
- gnt  out  4  registered one-hot grant; all zero when idle.
- gnt_id  out  2  index of current owner; valid only while gnt_valid = 1.
- gnt_valid  out  1  high while any grant is asserted, equal to |gnt.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset state: IDLE; gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, hold counter = 0, last_id = 0.
- State IDLE:
  - If req is zero, the block stays in IDLE.
  - If req is nonzero, the block picks a winner, registers gnt, gnt_id and last_id, loads the hold counter with 1, and moves to BUSY.
- Fixed priority (rr_en = 0): the highest-index active request wins, so req[3] beats req[0].
- Round-robin (rr_en = 1):
  - Search order is descending from (last_id − 1) mod 4, wrapping, and ends at last_id itself.
  - The last owner therefore has lowest priority.
  - With last_id = 0 after reset, the order is 3, 2, 1, 0, which is identical to fixed priority.
- State BUSY: the grant ends when either of these is true in a cycle:
  - release = 1, or
  - req[gnt_id] = 0 (the owner withdrew its request).
  In either case gnt clears on the next edge and the state returns to IDLE.
- Timeout: if HOLD_MAX ≠ 0, the hold counter equals HOLD_MAX, and neither end condition is present:
  - gnt clears on the next edge and the state goes to IDLE.
  - timeout pulses high for exactly that one cycle.
  - Otherwise the counter increments every BUSY cycle and saturates at its width.
- Simultaneous events: release takes precedence over timeout. If both are true in the same cycle, the grant ends normally and timeout stays 0.
- After a timeout in fixed mode, the same requester may win again on the next arbitration. In round-robin mode, other active requesters win first.
- Requests from non-owners during BUSY are ignored; there is no preemption.
- A change on rr_en during BUSY takes effect at the next IDLE arbitration.
- rst asserted during BUSY: all outputs return to their reset values on that edge, and last_id returns to 0.

## Timing
- Grant latency: req goes high in cycle t while IDLE → gnt asserted from cycle t+1.
- Release latency: release sampled in cycle t → gnt = 0 in cycle t+1, which is a mandatory one-cycle idle bubble.
  - If requests are still pending, the next grant appears in cycle t+2.
- Maximum grant length is HOLD_MAX cycles. timeout is high in cycle t+HOLD_MAX+1 relative to the grant rising in t+1, coincident with gnt = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Sustained full load (all req = 1, release every grant after 1 cycle): one grant every 2 cycles.

## Structure
- Package arb_pkg holds:
  - N_REQ = 4 and ID_W = 2.
  - The state enum {IDLE, BUSY}.
  - A rotate function that reorders req so that index (last_id − 1) mod 4 lands at the top position.
- Sub-module arb_pick_4: combinational 4-input priority picker (highest bit wins) returning a 2-bit index and a hit flag.
  - Used in both modes.
  - In round-robin mode it is fed the rotated vector, and its index is un-rotated before being registered.

## Test plan
- Fixed priority: rst released, rr_en = 0, req = 4'b0101 → gnt = 4'b0100 and gnt_id = 2 one cycle later. Then release = 1 for one cycle → gnt = 0 for one cycle, then gnt = 4'b0100 again.
- Round-robin fairness: rr_en = 1, req held at 4'b1111, release pulsed on every grant cycle → grant order 3, 2, 1, 0, 3 with one zero-gnt bubble between consecutive grants.
- Timeout: HOLD_MAX = 4, req = 4'b0010, release never asserted → gnt = 4'b0010 for exactly 4 cycles, then gnt = 0 with a single-cycle timeout = 1, then a re-grant to requester 1.
- Owner withdrawal and release/timeout collision:
  - Owner 2 drops req[2] mid-grant → gnt clears the next cycle and timeout stays 0.
  - release = 1 in the HOLD_MAX cycle → timeout stays 0.
- Reset mid-grant: rst asserted for one cycle while gnt = 4'b1000 in round-robin mode → all outputs 0 the next cycle. A subsequent req = 4'b1001 grants requester 3 (last_id was reset to 0).
